message_rx: RTL and testbench
=============================

# message_rx

Receive-side counterpart of the UART message-mode transmitter. Deserialises an 8N1 UART stream on `rxd` and assembles consecutive bytes into a fixed-length message buffer. When the buffer is full, it compares the buffer against an expected string and reports pass/fail. It sits on the board's UART input and drives the debug LEDs/display with the last received byte and the match flag.

## Interface
- `CLKS_PER_BIT`, 10417: clk cycles per UART bit (100 MHz / 9600 baud); must be ≥ 8.
- `MSG_LEN`, 12: bytes per message.
- `EXPECTED`, "hello world!": 8·MSG_LEN-bit expected message, first character in the MSBs.
- `TIMEOUT_BITS`, 20: idle bit-times inside a partial message before it is abandoned.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `rxd` in 1: UART line, idle high, asynchronous to clk.
- `word` out 8: last correctly framed byte.
- `word_valid` out 1: one-cycle pulse when `word` updates.
- `msg` out 8·MSG_LEN: completed message, first byte in the MSBs.
- `msg_valid` out 1: one-cycle pulse when `msg` updates.
- `msg_match` out 1: `msg == EXPECTED`; held until the next `msg_valid`.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.

## Operation
- **Input synchroniser.** `rxd` passes through a 2-flop synchroniser, both flops reset to 1. All logic uses the synchronised bit `rx_s`.
- **Bit FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `rx_s` = 0 → START, and the bit counter `bcnt` clears.
  - START: when `bcnt` = CLKS_PER_BIT/2−1, re-sample `rx_s`. If 0 → DATA, `bcnt` = 0, bit index = 0. If 1 (glitch) → IDLE, with no output.
  - DATA: when `bcnt` = CLKS_PER_BIT−1, shift `rx_s` into the shift register LSB-first and clear `bcnt`. After bit index 7 → STOP.
  - STOP: when `bcnt` = CLKS_PER_BIT−1, sample `rx_s`.
    - 1: `word` ← shift register, pulse `word_valid`, append the byte to the message.
    - 0: pulse `frame_err`, discard the byte, reset the message byte count to 0.
    - Either case → IDLE.
- **Message assembly.**
  - Buffer `buf` (8·MSG_LEN bits) shifts left by 8 with the new byte in the LSBs. Byte count `mcnt` increments.
  - When a byte makes `mcnt` reach MSG_LEN, on the same edge:
    - `msg` ← the shifted buffer.
    - `msg_match` ← (shifted buffer == EXPECTED).
    - `msg_valid` pulses.
    - `mcnt` ← 0.
  - `mcnt` is 0..MSG_LEN−1 and never wraps past MSG_LEN.
- **Timeout.**
  - While `mcnt` ≠ 0 and the FSM is in IDLE, a timeout counter counts clk cycles. It clears on any start detection.
  - At TIMEOUT_BITS·CLKS_PER_BIT cycles: `mcnt` ← 0 and `buf` ← 0. There is no pulse.
  - This resynchronises to the transmitter's inter-message gap.
- **Reset.** A mid-byte or mid-message reset abandons all progress. Every output takes its reset value on the next edge.

## Timing
- **Reset values:**
  - `word` = 0, `word_valid` = 0
  - `msg` = 0, `msg_valid` = 0, `msg_match` = 0
  - `frame_err` = 0
  - FSM = IDLE, all counters 0
- **Latency.** From the first clk where `rx_s` = 0 in IDLE to the `word_valid` edge: CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles. Add 2 cycles of synchroniser delay from `rxd`.
- **Outputs.** `msg_valid` and `word_valid` for the final byte assert in the same cycle. `word_valid`, `msg_valid` and `frame_err` are single-cycle pulses and are registered.
- **Back-to-back frames.** A start bit immediately after the stop bit is accepted. The FSM is in IDLE from the cycle after the stop-bit sample, so there is a 1-cycle minimum gap.
- **Throughput.** One byte per 10 bit times. No flow control; the consumer must accept `word_valid` every cycle it pulses.
- **Simultaneous events.** If the timeout expiry and a start detection fall on the same cycle, the start wins: the timeout clears and `mcnt` is kept.

## Test plan
- **Nominal message.** CLKS_PER_BIT = 16. Send "hello world!" as 12 back-to-back frames → 12 `word_valid` pulses with bytes 0x68…0x21. `msg_valid` on the 12th byte, `msg` = "hello world!", `msg_match` = 1.
- **Mismatch.** Send "hello world?" → `msg_valid` with `msg_match` = 0, and `word` = 0x3F at the end.
- **Framing error.** Send "hel", then a frame with the stop bit low, then "lo world!" plus 3 more bytes → one `frame_err`, no `word_valid` for the bad frame. The next `msg_valid` fires only after 12 good bytes following the error.
- **Glitch rejection.** Drive a 4-cycle low pulse on `rxd` while idle → the FSM returns to IDLE with no pulses. A following valid 0x55 frame is received correctly.
- **Timeout resync.** Send 5 bytes, idle 25 bit-times, then send "hello world!" → exactly one `msg_valid` with `msg_match` = 1.
- **Reset mid-byte.** Assert `rst` for 1 cycle during DATA bit 3 → all outputs 0 on the next edge. A subsequent full message is received with `msg_match` = 1.

Source files
------------

// File: rtl/message_rx.sv
`default_nettype none
// ============================================================================
// Module      : message_rx
// Description : 8N1 UART receiver that assembles fixed-length messages and
//               flags whether each completed message equals EXPECTED.
// Revision    : 1.0 - initial release
// ============================================================================
module message_rx #(
  parameter int                    CLKS_PER_BIT = 10417,
  parameter int                    MSG_LEN      = 12,
  parameter logic [8*MSG_LEN-1:0]  EXPECTED     = "hello world!",
  parameter int                    TIMEOUT_BITS = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rxd,
  output logic [7:0]               word,
  output logic                     word_valid,
  output logic [8*MSG_LEN-1:0]     msg,
  output logic                     msg_valid,
  output logic                     msg_match,
  output logic                     frame_err
);

  localparam int c_BUF_W     = 8 * MSG_LEN;
  localparam int c_BCNT_W    = $clog2(CLKS_PER_BIT);
  localparam int c_MCNT_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int c_TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int c_TCNT_W    = (c_TO_CYCLES > 1) ? $clog2(c_TO_CYCLES) : 1;

  localparam logic [c_BCNT_W-1:0] c_HALF  = c_BCNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_BCNT_W-1:0] c_FULL  = c_BCNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_MCNT_W-1:0] c_MLAST = c_MCNT_W'(MSG_LEN - 1);
  localparam logic [c_TCNT_W-1:0] c_TLAST = c_TCNT_W'(c_TO_CYCLES - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  logic                r_sync1;
  logic                r_rx_s;
  logic [1:0]          r_state;
  logic [c_BCNT_W-1:0] r_bcnt;
  logic [2:0]          r_bidx;
  logic [7:0]          r_shift;
  logic [c_BUF_W-1:0]  r_buf;
  logic [c_MCNT_W-1:0] r_mcnt;
  logic [c_TCNT_W-1:0] r_tcnt;

  logic                w_start;
  logic                w_stop_sample;
  logic                w_byte_ok;
  logic                w_byte_bad;
  logic                w_to_active;
  logic                w_timeout;
  logic [c_BUF_W-1:0]  w_buf_next;

  // rxd is asynchronous; both flops idle high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_rx_s  <= r_sync1;
    end
  end

  assign w_start       = (r_state == c_IDLE) && !r_rx_s;
  assign w_stop_sample = (r_state == c_STOP) && (r_bcnt == c_FULL);
  assign w_byte_ok     = w_stop_sample && r_rx_s;
  assign w_byte_bad    = w_stop_sample && !r_rx_s;
  assign w_to_active   = (r_state == c_IDLE) && (r_mcnt != '0);
  // a start detection on the expiry cycle takes priority and keeps the partial message
  assign w_timeout     = w_to_active && !w_start && (r_tcnt == c_TLAST);
  assign w_buf_next    = (r_buf << 8) | c_BUF_W'(r_shift);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_bcnt  <= '0;
      r_bidx  <= 3'd0;
      r_shift <= 8'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (!r_rx_s) begin
            r_state <= c_START;
            r_bcnt  <= '0;
          end
        end
        c_START: begin
          if (r_bcnt == c_HALF) begin
            r_bcnt <= '0;
            r_bidx <= 3'd0;
            r_state <= r_rx_s ? c_IDLE : c_DATA;
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
        c_DATA: begin
          if (r_bcnt == c_FULL) begin
            r_bcnt  <= '0;
            r_shift <= {r_rx_s, r_shift[7:1]};
            if (r_bidx == 3'd7) begin
              r_state <= c_STOP;
            end else begin
              r_bidx <= r_bidx + 1'b1;
            end
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
        c_STOP: begin
          if (r_bcnt == c_FULL) begin
            r_bcnt  <= '0;
            r_state <= c_IDLE;
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_bcnt  <= '0;
        end
      endcase
    end
  end

  // Inter-message gap detector
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt <= '0;
    end else if (w_to_active && !w_start && (r_tcnt != c_TLAST)) begin
      r_tcnt <= r_tcnt + 1'b1;
    end else begin
      r_tcnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word       <= 8'd0;
      word_valid <= 1'b0;
      msg        <= '0;
      msg_valid  <= 1'b0;
      msg_match  <= 1'b0;
      frame_err  <= 1'b0;
      r_buf      <= '0;
      r_mcnt     <= '0;
    end else begin
      word_valid <= 1'b0;
      msg_valid  <= 1'b0;
      frame_err  <= 1'b0;
      if (w_byte_ok) begin
        word       <= r_shift;
        word_valid <= 1'b1;
        r_buf      <= w_buf_next;
        if (r_mcnt == c_MLAST) begin
          msg       <= w_buf_next;
          msg_match <= (w_buf_next == EXPECTED);
          msg_valid <= 1'b1;
          r_mcnt    <= '0;
        end else begin
          r_mcnt <= r_mcnt + 1'b1;
        end
      end else if (w_byte_bad) begin
        frame_err <= 1'b1;
        r_mcnt    <= '0;
      end else if (w_timeout) begin
        r_mcnt <= '0;
        r_buf  <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_message_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_message_rx
// Description : Randomised self-checking bench for message_rx against a
//               byte/message-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_message_rx;

  localparam int          C   = 16;
  localparam int          L   = 12;
  localparam int          TB  = 20;
  localparam logic [95:0] EXP = "hello world!";

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic [7:0]  word;
  logic        word_valid;
  logic [95:0] msg;
  logic        msg_valid;
  logic        msg_match;
  logic        frame_err;

  message_rx #(
    .CLKS_PER_BIT(C),
    .MSG_LEN     (L),
    .EXPECTED    (EXP),
    .TIMEOUT_BITS(TB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .word      (word),
    .word_valid(word_valid),
    .msg       (msg),
    .msg_valid (msg_valid),
    .msg_match (msg_match),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_words[$];
  logic [7:0]  obs_words[$];
  logic [95:0] exp_msgs[$];
  logic [95:0] obs_msgs[$];
  bit          exp_match[$];
  bit          obs_match[$];
  int          exp_ferr = 0;
  int          obs_ferr = 0;
  int          obs_msg_nowrd = 0;
  logic [7:0]  model_buf[$];
  int          w0, m0, f0;

  // Observed event streams, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (word_valid) obs_words.push_back(word);
      if (msg_valid) begin
        obs_msgs.push_back(msg);
        obs_match.push_back(msg_match);
        if (!word_valid) obs_msg_nowrd++;
      end
      if (frame_err) obs_ferr++;
    end
  end

  task automatic model_byte(input logic [7:0] b, input bit good);
    logic [95:0] m;
    if (!good) begin
      exp_ferr++;
      model_buf.delete();
    end else begin
      exp_words.push_back(b);
      model_buf.push_back(b);
      if (model_buf.size() == L) begin
        m = '0;
        foreach (model_buf[i]) m = {m[87:0], model_buf[i]};
        exp_msgs.push_back(m);
        exp_match.push_back(m == EXP);
        model_buf.delete();
      end
    end
  endtask

  task automatic model_idle(input int bit_times);
    if (bit_times >= TB) model_buf.delete();
  endtask

  task automatic mark();
    w0 = obs_words.size();
    m0 = obs_msgs.size();
    f0 = obs_ferr;
    exp_words.delete();
    exp_msgs.delete();
    exp_match.delete();
    exp_ferr = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input int gap);
    model_byte(b, stop);
    rxd = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (C) @(negedge clk);
    end
    rxd = stop;
    repeat (C) @(negedge clk);
    rxd = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_range(input logic [95:0] s, input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) send_frame(s[95-8*i -: 8], 1'b1, gap);
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * C) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (word !== 8'd0) begin errors++; $display("FAIL reset word: got %h expected 00", word); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset word_valid: got %b expected 0", word_valid); end
    checks++; if (msg !== 96'd0) begin errors++; $display("FAIL reset msg: got %h expected 0", msg); end
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL reset msg_valid: got %b expected 0", msg_valid); end
    checks++; if (msg_match !== 1'b0) begin errors++; $display("FAIL reset msg_match: got %b expected 0", msg_match); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset frame_err: got %b expected 0", frame_err); end
    rst = 1'b0;
    idle_bits(2);
  endtask

  task automatic test_nominal();
    mark();
    send_range(EXP, 0, L-1, 0);
    idle_bits(2);
    checks++; if (obs_words.size()-w0 != exp_words.size()) begin errors++; $display("FAIL nominal word_count: got %0d expected %0d", obs_words.size()-w0, exp_words.size()); end
    foreach (exp_words[i]) if (w0+i < obs_words.size()) begin
      checks++; if (obs_words[w0+i] !== exp_words[i]) begin errors++; $display("FAIL nominal word[%0d]: got %h expected %h", i, obs_words[w0+i], exp_words[i]); end
    end
    checks++; if (obs_msgs.size()-m0 != 1) begin errors++; $display("FAIL nominal msg_count: got %0d expected 1", obs_msgs.size()-m0); end
    checks++; if (msg !== EXP || msg_match !== 1'b1) begin errors++; $display("FAIL nominal msg: got %h match %b expected %h match 1", msg, msg_match, EXP); end
    checks++; if (obs_msg_nowrd !== 0) begin errors++; $display("FAIL nominal msg_word_same_cycle: got %0d stray msg_valid expected 0", obs_msg_nowrd); end
  endtask

  task automatic test_mismatch();
    logic [95:0] s;
    s = "hello world?";
    mark();
    send_range(s, 0, L-1, 0);
    idle_bits(2);
    checks++; if (obs_msgs.size()-m0 != 1) begin errors++; $display("FAIL mismatch msg_count: got %0d expected 1", obs_msgs.size()-m0); end
    checks++; if (msg !== s || msg_match !== 1'b0) begin errors++; $display("FAIL mismatch msg: got %h match %b expected %h match 0", msg, msg_match, s); end
    checks++; if (word !== 8'h3F) begin errors++; $display("FAIL mismatch last_word: got %h expected 3f", word); end
  endtask

  task automatic test_frame_error();
    mark();
    send_range(EXP, 0, 2, 0);
    send_frame(8'($urandom_range(0, 255)), 1'b0, 2*C);
    send_range(EXP, 3, L-1, 0);
    idle_bits(1);
    checks++; if (obs_msgs.size()-m0 != 0) begin errors++; $display("FAIL frame_err early_msg: got %0d msg_valid expected 0", obs_msgs.size()-m0); end
    for (int i = 0; i < 3; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, $urandom_range(0, 3));
    idle_bits(2);
    checks++; if (obs_ferr-f0 != exp_ferr) begin errors++; $display("FAIL frame_err count: got %0d expected %0d", obs_ferr-f0, exp_ferr); end
    checks++; if (obs_words.size()-w0 != exp_words.size()) begin errors++; $display("FAIL frame_err word_count: got %0d expected %0d", obs_words.size()-w0, exp_words.size()); end
    checks++; if (obs_msgs.size()-m0 != exp_msgs.size()) begin errors++; $display("FAIL frame_err msg_count: got %0d expected %0d", obs_msgs.size()-m0, exp_msgs.size()); end
    foreach (exp_msgs[i]) if (m0+i < obs_msgs.size()) begin
      checks++; if (obs_msgs[m0+i] !== exp_msgs[i] || obs_match[m0+i] !== exp_match[i]) begin errors++; $display("FAIL frame_err msg[%0d]: got %h/%b expected %h/%b", i, obs_msgs[m0+i], obs_match[m0+i], exp_msgs[i], exp_match[i]); end
    end
  endtask

  task automatic test_glitch();
    int w;
    mark();
    w = $urandom_range(1, 6);
    rxd = 1'b0;
    repeat (w) @(negedge clk);
    rxd = 1'b1;
    repeat (2*C) @(negedge clk);
    checks++; if (obs_words.size() != w0 || obs_msgs.size() != m0 || obs_ferr != f0) begin errors++; $display("FAIL glitch pulses: got %0d words %0d msgs %0d ferr expected none (width %0d)", obs_words.size()-w0, obs_msgs.size()-m0, obs_ferr-f0, w); end
    send_frame(8'h55, 1'b1, 0);
    idle_bits(2);
    checks++; if (obs_words.size()-w0 != 1) begin errors++; $display("FAIL glitch follow_count: got %0d expected 1", obs_words.size()-w0); end
    else begin
      checks++; if (obs_words[w0] !== exp_words[0]) begin errors++; $display("FAIL glitch follow_word: got %h expected %h", obs_words[w0], exp_words[0]); end
    end
  endtask

  task automatic test_timeout();
    mark();
    for (int i = 0; i < 5; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 0);
    idle_bits(25);
    model_idle(25);
    send_range(EXP, 0, L-1, 0);
    idle_bits(2);
    checks++; if (obs_msgs.size()-m0 != exp_msgs.size()) begin errors++; $display("FAIL timeout msg_count: got %0d expected %0d", obs_msgs.size()-m0, exp_msgs.size()); end
    foreach (exp_msgs[i]) if (m0+i < obs_msgs.size()) begin
      checks++; if (obs_msgs[m0+i] !== exp_msgs[i] || obs_match[m0+i] !== exp_match[i]) begin errors++; $display("FAIL timeout msg[%0d]: got %h/%b expected %h/%b", i, obs_msgs[m0+i], obs_match[m0+i], exp_msgs[i], exp_match[i]); end
    end
  endtask

  task automatic test_timeout_hold();
    mark();
    for (int i = 0; i < 5; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 0);
    idle_bits(18);
    model_idle(18);
    for (int i = 0; i < 7; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 0);
    idle_bits(2);
    checks++; if (obs_msgs.size()-m0 != exp_msgs.size()) begin errors++; $display("FAIL hold msg_count: got %0d expected %0d", obs_msgs.size()-m0, exp_msgs.size()); end
    foreach (exp_msgs[i]) if (m0+i < obs_msgs.size()) begin
      checks++; if (obs_msgs[m0+i] !== exp_msgs[i] || obs_match[m0+i] !== exp_match[i]) begin errors++; $display("FAIL hold msg[%0d]: got %h/%b expected %h/%b", i, obs_msgs[m0+i], obs_match[m0+i], exp_msgs[i], exp_match[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit good;
    mark();
    for (int i = 0; i < 3*L; i++) begin
      good = ($urandom_range(0, 15) != 0);
      send_frame(8'($urandom_range(0, 255)), good, good ? $urandom_range(0, 3) : 2*C);
    end
    idle_bits(2);
    checks++; if (obs_ferr-f0 != exp_ferr) begin errors++; $display("FAIL b2b ferr_count: got %0d expected %0d", obs_ferr-f0, exp_ferr); end
    checks++; if (obs_words.size()-w0 != exp_words.size()) begin errors++; $display("FAIL b2b word_count: got %0d expected %0d", obs_words.size()-w0, exp_words.size()); end
    foreach (exp_words[i]) if (w0+i < obs_words.size()) begin
      checks++; if (obs_words[w0+i] !== exp_words[i]) begin errors++; $display("FAIL b2b word[%0d]: got %h expected %h", i, obs_words[w0+i], exp_words[i]); end
    end
    checks++; if (obs_msgs.size()-m0 != exp_msgs.size()) begin errors++; $display("FAIL b2b msg_count: got %0d expected %0d", obs_msgs.size()-m0, exp_msgs.size()); end
    foreach (exp_msgs[i]) if (m0+i < obs_msgs.size()) begin
      checks++; if (obs_msgs[m0+i] !== exp_msgs[i] || obs_match[m0+i] !== exp_match[i]) begin errors++; $display("FAIL b2b msg[%0d]: got %h/%b expected %h/%b", i, obs_msgs[m0+i], obs_match[m0+i], exp_msgs[i], exp_match[i]); end
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] b;
    b = 8'hA5;
    rxd = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd = b[i];
      repeat (C) @(negedge clk);
    end
    rxd = b[3];
    repeat (C/2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rxd = 1'b1;
    checks++; if ({word, word_valid, msg_valid, msg_match, frame_err} !== 12'd0 || msg !== 96'd0) begin errors++; $display("FAIL rst_mid outputs: got word %h wv %b msg %h mv %b mm %b fe %b expected all 0", word, word_valid, msg, msg_valid, msg_match, frame_err); end
    model_buf.delete();
    idle_bits(2);
    mark();
    send_range(EXP, 0, L-1, $urandom_range(0, 3));
    idle_bits(2);
    checks++; if (obs_words.size()-w0 != exp_words.size()) begin errors++; $display("FAIL rst_mid word_count: got %0d expected %0d", obs_words.size()-w0, exp_words.size()); end
    checks++; if (obs_msgs.size()-m0 != 1) begin errors++; $display("FAIL rst_mid msg_count: got %0d expected 1", obs_msgs.size()-m0); end
    checks++; if (msg !== EXP || msg_match !== 1'b1) begin errors++; $display("FAIL rst_mid msg: got %h match %b expected %h match 1", msg, msg_match, EXP); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_mismatch();
    test_frame_error();
    test_glitch();
    test_timeout();
    test_timeout_hold();
    test_back_to_back();
    test_reset_mid_byte();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
